// File: rtl/piso_tx_ctrl.sv
// Parallel-in/serial-out transmit controller: valid/ready word intake, framed
// serial output with sof/eof strobes, done pulse and a programmable idle gap.
module piso_tx_ctrl #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             so,
    output logic             so_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit            B2B      = (GAP == 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == S_SHIFT) && (bit_cnt == LAST);
    // Back-to-back reload is only offered on the eof cycle when no gap is configured.
    assign in_ready = rst_n && ((state == S_IDLE) || (B2B && last_bit));
    assign accept   = in_valid && in_ready;
    assign shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    assign so_valid = (state == S_SHIFT);
    assign so       = so_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign sof      = so_valid && (bit_cnt == '0);
    assign eof      = last_bit;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_bit;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        if (accept) begin
                            shreg <= in_data;
                        end else begin
                            shreg   <= shifted;
                            gap_cnt <= GAP_LOAD;
                            state   <= (GAP > 0) ? S_GAP : S_IDLE;
                        end
                    end else begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Transmit controller that sequences a parallel-in/serial-out shift register. It accepts parallel words from an upstream producer over a valid/ready handshake, loads them into an internal shift register and shifts them out one bit per clock. It frames each word with sof/eof/valid strobes and inserts a programmable idle gap between frames. It sits between a word-oriented source (FIFO, register file) and a single-wire serial link.

Parameters:
WIDTH, 4, word width in bits (2..32).
GAP, 1, idle cycles inserted after each frame (0..15).
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word available.
in_data  input  WIDTH  upstream word; sampled only on handshake.
in_ready  output  1  controller can accept a word this cycle.
so  output  1  serial data bit.
so_valid  output  1  so carries a frame bit this cycle.
sof  output  1  first bit of frame (high with so_valid).
eof  output  1  last bit of frame (high with so_valid).
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse, cycle after each eof.

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE, shift reg=0, bit count=0, gap count=0; so=0, so_valid=0, sof=0, eof=0, busy=0, done=0, in_ready=0. in_ready rises combinationally once rst_n=1 (IDLE).
- States: IDLE, SHIFT, GAP. Outputs so/so_valid/sof/eof/busy are Moore (decoded from registers); in_ready is decoded from state plus bit count.
- Handshake: accept when in_valid && in_ready at posedge. in_data captured into shift reg, bit count=0, next state SHIFT. No accept -> in_data ignored, no state change.
- IDLE: in_ready=1, so_valid=0, so=0.
- SHIFT: so_valid=1; so = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); sof=1 when bit count=0; eof=1 when bit count=WIDTH-1. Each posedge: shift toward the output end, filling with 0; bit count +1.
- Latency: handshake at edge E0 -> first bit visible cycle after E0; frame occupies exactly WIDTH consecutive cycles.
- End of frame (edge leaving bit WIDTH-1): GAP>0 -> GAP state, gap count=GAP-1. GAP=0 -> IDLE, except back-to-back case below.
- Back-to-back (GAP=0 only): in_ready=1 also during the eof cycle; accept there reloads shreg and stays in SHIFT, so next frame's sof immediately follows eof with no idle cycle.
- GAP: in_ready=0, so_valid=0, so=0, busy=1; count down; leave to IDLE on edge where gap count=0. Frame-to-frame spacing therefore = GAP idle cycles + 1 IDLE cycle minimum (GAP>0).
- done: registered, high exactly one cycle following each eof cycle, including back-to-back frames and entry into GAP.
- WIDTH=1: sof and eof both high on the single bit.
- Reset mid-frame: immediate abort; outputs go to reset values asynchronously; no done, partial frame discarded; next frame starts only after new handshake.
- in_valid held with in_ready=0: word held by upstream, not lost; no combinational path in_valid -> in_ready.

Test Plan:
- Reset then single word: WIDTH=4, GAP=1, MSB_FIRST=1, in_data=4'b1011 accepted at E0 -> so=1,0,1,1 on cycles 1..4, sof cycle 1, eof cycle 4, done cycle 5, in_ready low cycles 1..5, high cycle 6.
- LSB-first: MSB_FIRST=0, in_data=4'b1000 -> so=0,0,0,1; so_valid exactly 4 cycles.
- Back-to-back: GAP=0, in_valid held with 4'hA then 4'h5 -> so=1,0,1,0,0,1,0,1 with no gap, sof on cycles 1 and 5, done on cycles 5 and 9.
- Gap enforcement: GAP=3, in_valid always 1 -> exactly 3 cycles so_valid=0 plus 1 IDLE accept cycle between eof and next sof; in_ready low throughout GAP.
- Reset mid-frame: drop rst_n during bit 2 of 4'b1111 -> so/so_valid/busy=0 immediately, no done pulse; after release, new word 4'b0110 serialises correctly from sof.
- Backpressure/ignore: toggle in_data while busy with in_valid=1 -> only value present at accept edge is transmitted; no word dropped or duplicated over 16 random words (scoreboard).
